// File: rtl/muldiv.sv
// Iterative 16-bit multiply / unsigned divide unit: 16 cycles per operation,
// one radix-2 shift-add or restoring shift-subtract step per cycle.
`ifndef RW
`define RW 16
`endif
`ifndef ALU_FLAG_CNT
`define ALU_FLAG_CNT 5
`endif

module muldiv (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [`RW-1:0]           i_l,
  input  logic [`RW-1:0]           i_r,
  input  logic [1:0]               i_mode,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [`RW-1:0]           o_out,
  output logic [`ALU_FLAG_CNT-1:0] o_flags,
  output logic                     o_valid,
  input  logic                     i_res_ready,
  input  logic                     i_flush
);

  localparam int RW       = `RW;
  localparam int FLAG_CNT = `ALU_FLAG_CNT;
  localparam int CNT_W    = $clog2(RW);

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_O = 3;
  localparam int FLAG_P = 4;

  localparam logic [1:0] MODE_MUL  = 2'b00;
  localparam logic [1:0] MODE_MULH = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic [CNT_W-1:0]   cnt;
  logic [2*RW-1:0]    acc;
  logic [2*RW-1:0]    acc_step;
  logic [RW-1:0]      opnd;
  logic [1:0]         mode;
  logic [RW-1:0]      result;
  logic               carry;

  // One shift-add step: the multiplier sits in acc[RW-1:0] and is consumed LSB
  // first while the partial product grows into the upper half.
  function automatic logic [2*RW-1:0] mul_step(input logic [2*RW-1:0] a,
                                               input logic [RW-1:0]   m);
    logic [RW:0] sum;
    sum = {1'b0, a[2*RW-1:RW]} + (a[0] ? {1'b0, m} : {(RW+1){1'b0}});
    return {sum, a[RW-1:1]};
  endfunction

  // One restoring step: remainder in acc[2RW-1:RW], dividend shifts out of the
  // low half while quotient bits shift in. A zero divisor always "fits",
  // which naturally yields quotient all-ones and remainder = dividend.
  function automatic logic [2*RW-1:0] div_step(input logic [2*RW-1:0] a,
                                               input logic [RW-1:0]   d);
    logic [RW:0]   t;
    logic [RW-1:0] diff;
    t    = a[2*RW-1:RW-1];
    diff = t[RW-1:0] - d;
    if (t >= {1'b0, d})
      return {diff, a[RW-2:0], 1'b1};
    else
      return {t[RW-1:0], a[RW-2:0], 1'b0};
  endfunction

  function automatic logic [FLAG_CNT-1:0] make_flags(input logic [RW-1:0] res,
                                                     input logic          c);
    logic [FLAG_CNT-1:0] f;
    f         = '0;
    f[FLAG_Z] = (res == '0);
    f[FLAG_N] = res[RW-1];
    f[FLAG_C] = c;
    f[FLAG_O] = 1'b0;
    f[FLAG_P] = ^res;
    return f;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Flush outranks both acceptance and retirement.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid && !i_flush) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (i_flush)                        state_nxt = IDLE;
        else if (cnt == CNT_W'(RW - 1))     state_nxt = DONE;
      end
      DONE: begin
        if (i_flush || i_res_ready)         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign acc_step = mode[1] ? div_step(acc, opnd) : mul_step(acc, opnd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      opnd <= '0;
      mode <= MODE_MUL;
    end else if (accept) begin
      cnt  <= '0;
      mode <= i_mode;
      opnd <= i_mode[1] ? i_r : i_l;
      acc  <= {{RW{1'b0}}, (i_mode[1] ? i_l : i_r)};
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= acc_step;
    end
  end

  // Low half holds product-low / quotient, high half product-high / remainder.
  always_comb begin
    result = mode[0] ? acc[2*RW-1:RW] : acc[RW-1:0];
    carry  = 1'b0;
    if (mode[1])                carry = (opnd == '0);
    else if (mode == MODE_MUL)  carry = (acc[2*RW-1:RW] != '0);
    else if (mode == MODE_MULH) carry = 1'b0;
  end

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_out   = o_valid ? result : '0;
  assign o_flags = o_valid ? make_flags(result, carry) : '0;

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: scoreboard of reference results, latency,
// backpressure, flush and asynchronous reset behaviour.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] l, r;
  logic [1:0]  mode;
  logic        valid;
  logic        ready;
  logic [15:0] out;
  logic [4:0]  flags;
  logic        out_valid;
  logic        res_ready;
  logic        flush;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] out;
    logic [4:0]  flags;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_l        (l),
    .i_r        (r),
    .i_mode     (mode),
    .i_valid    (valid),
    .o_ready    (ready),
    .o_out      (out),
    .o_flags    (flags),
    .o_valid    (out_valid),
    .i_res_ready(res_ready),
    .i_flush    (flush)
  );

  // Flag layout: Z=0, N=1, C=2, O=3, P=4
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] m);
    logic [31:0] p;
    exp_t        e;
    logic        c;
    p = {16'b0, a} * {16'b0, b};
    c = 1'b0;
    case (m)
      2'b00: begin e.out = p[15:0];  c = (p[31:16] != 16'h0); end
      2'b01: begin e.out = p[31:16]; c = 1'b0; end
      2'b10: begin e.out = (b == 0) ? 16'hFFFF : a / b; c = (b == 0); end
      default: begin e.out = (b == 0) ? a : a % b; c = (b == 0); end
    endcase
    e.flags = {^e.out, 1'b0, c, e.out[15], (e.out == 16'h0)};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
    l     = a;
    r     = b;
    mode  = m;
    valid = 1'b1;
    step();
    valid = 1'b0;
    sb.push_back(model(a, b, m));
  endtask

  // Waits the fixed 16-iteration latency and compares against the scoreboard head.
  task automatic expect_result(input string tag);
    exp_t e;
    repeat (15) step();
    check({tag, "_early_valid"}, out_valid, 0);
    step();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_busy"}, ready, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_out"}, out, e.out);
      check({tag, "_flags"}, flags, e.flags);
    end
  endtask

  // Retire with res_ready high while offering a new request on the same edge.
  task automatic retire(input string tag);
    res_ready = 1'b1;
    valid     = 1'b1;
    l         = 16'h5555;
    r         = 16'h0003;
    step();
    valid = 1'b0;
    check({tag, "_ret_valid"}, out_valid, 0);
    check({tag, "_ret_ready"}, ready, 1);
    check({tag, "_ret_out"}, out, 0);
    check({tag, "_ret_flags"}, flags, 0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] m);
    start(a, b, m);
    expect_result(tag);
    retire(tag);
  endtask

  initial begin
    exp_t        held;
    logic [15:0] ra, rb;

    rst_n = 1'b0; l = '0; r = '0; mode = '0; valid = 1'b0;
    res_ready = 1'b1; flush = 1'b0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul7x6", 16'h0007, 16'h0006, 2'b00);
    run_op("mul_ffff", 16'hFFFF, 16'hFFFF, 2'b00);
    run_op("mulh_ffff", 16'hFFFF, 16'hFFFF, 2'b01);
    run_op("div100_7", 16'h0064, 16'h0007, 2'b10);
    run_op("mod100_7", 16'h0064, 16'h0007, 2'b11);
    run_op("div_by0", 16'h1234, 16'h0000, 2'b10);
    run_op("mod_by0", 16'h1234, 16'h0000, 2'b11);
    run_op("div_exact", 16'hFFFF, 16'h0001, 2'b10);
    run_op("mul_zero", 16'h0000, 16'hBEEF, 2'b00);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, 2'(i % 4));
    end

    // Backpressure: hold result for 5 cycles while new requests are offered.
    res_ready = 1'b0;
    start(16'h0123, 16'h0456, 2'b00);
    held = model(16'h0123, 16'h0456, 2'b00);
    expect_result("bp");
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      l     = 16'(i + 9);
      r     = 16'h0002;
      mode  = 2'b10;
      step();
      check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
      check($sformatf("bp_hold_out%0d", i), out, held.out);
      check($sformatf("bp_hold_flags%0d", i), flags, held.flags);
    end
    valid = 1'b0;
    retire("bp");
    repeat (17) step();
    check("bp_no_ghost", out_valid, 0);

    // Flush at iteration 8.
    start(16'h00FF, 16'h00FF, 2'b00);
    repeat (8) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ready", ready, 1);
    check("flush_valid", out_valid, 0);
    repeat (10) step();
    check("flush_no_result", out_valid, 0);
    void'(sb.pop_back());

    // Flush together with valid in IDLE: no accept.
    valid = 1'b1; flush = 1'b1; l = 16'h0003; r = 16'h0003; mode = 2'b00;
    step();
    valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", ready, 1);
    repeat (16) step();
    check("flush_idle_valid", out_valid, 0);

    // Asynchronous reset at iteration 8, then accept on the first edge.
    start(16'h0100, 16'h0003, 2'b10);
    repeat (8) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", ready, 1);
    check("arst_valid", out_valid, 0);
    check("arst_out", out, 0);
    check("arst_flags", flags, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'h0009, 16'h0004, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
